// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_drive transmit port among P_REQ_NUM requesters.
// Optionally prefixes each accepted word with a header word carrying the requester index.
module uart_tx_arbiter #(
    parameter int P_REQ_NUM         = 4,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_HEADER_EN       = 1
) (
    input  logic                                   i_clk,
    input  logic                                   w_user_rst,
    input  logic [P_REQ_NUM-1:0]                   i_req_valid,
    input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
    output logic [P_REQ_NUM-1:0]                   o_req_ready,
    output logic [P_UART_DATA_WIDTH-1:0]           o_tx_data,
    output logic                                   o_tx_valid,
    input  logic                                   i_tx_ready,
    output logic [$clog2(P_REQ_NUM)-1:0]           o_grant_id,
    output logic                                   o_busy
);
    localparam int IDW = $clog2(P_REQ_NUM);
    localparam int W   = P_UART_DATA_WIDTH;
    localparam logic [IDW:0] LP_N = (IDW+1)'(P_REQ_NUM);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_grant_id;
    logic [W-1:0]     r_data_q;
    logic             r_busy;

    logic [P_REQ_NUM-1:0] w_win;
    logic                 w_found;
    logic [IDW-1:0]       w_idx;
    logic [IDW:0]         w_sum;
    logic [W-1:0]         w_sel;

    // Rotate the valid vector so bit 0 is rr_ptr, then map the first hit back modulo N.
    always_comb begin
        w_win   = P_REQ_NUM'({i_req_valid, i_req_valid} >> r_rr_ptr);
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int unsigned i = 0; i < P_REQ_NUM; i++) begin
            if (!w_found && w_win[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (IDW+1)'(i);
                w_idx   = (w_sum >= LP_N) ? IDW'(w_sum - LP_N) : IDW'(w_sum);
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < P_REQ_NUM; i++) begin
            if (w_idx == IDW'(i)) begin
                w_sel = i_req_data[i*W +: W];
            end
        end
    end

    // Held low during reset so no word is handed over that the registers would not capture.
    always_comb begin
        o_req_ready = '0;
        if (r_state == S_IDLE && w_found && !w_user_rst) begin
            for (int unsigned i = 0; i < P_REQ_NUM; i++) begin
                o_req_ready[i] = (w_idx == IDW'(i));
            end
        end
    end

    always_comb begin
        o_tx_data = '0;
        case (r_state)
            S_HDR:   o_tx_data = W'(r_grant_id);
            S_DATA:  o_tx_data = r_data_q;
            default: o_tx_data = '0;
        endcase
    end

    assign o_tx_valid = (r_state != S_IDLE);
    assign o_grant_id = r_grant_id;
    assign o_busy     = r_busy;

    always_ff @(posedge i_clk or posedge w_user_rst) begin
        if (w_user_rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_data_q   <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_data_q   <= w_sel;
                        r_grant_id <= w_idx;
                        r_rr_ptr   <= (w_idx == IDW'(P_REQ_NUM-1)) ? '0 : w_idx + 1'b1;
                        r_state    <= (P_HEADER_EN != 0) ? S_HDR : S_DATA;
                        r_busy     <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (i_tx_ready) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (i_tx_ready) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one header-on instance and one header-off instance,
// 4 requesters of 8-bit words each.
module tb_uart_tx_arbiter;
    logic       i_clk = 1'b0;
    logic       rst   = 1'b0;

    logic [3:0]  a_valid, a_ready, b_valid, b_ready;
    logic [31:0] a_data, b_data;
    logic [7:0]  a_txd, b_txd;
    logic        a_txv, a_txr, a_busy, b_txv, b_txr, b_busy;
    logic [1:0]  a_gid, b_gid;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] rr_exp [8] = '{8'h01, 8'h71, 8'h02, 8'h72, 8'h00, 8'h70, 8'h01, 8'h71};

    always #5 i_clk = ~i_clk;

    uart_tx_arbiter #(.P_REQ_NUM(4), .P_UART_DATA_WIDTH(8), .P_HEADER_EN(1)) dut_a (
        .i_clk(i_clk), .w_user_rst(rst), .i_req_valid(a_valid), .i_req_data(a_data),
        .o_req_ready(a_ready), .o_tx_data(a_txd), .o_tx_valid(a_txv), .i_tx_ready(a_txr),
        .o_grant_id(a_gid), .o_busy(a_busy));

    uart_tx_arbiter #(.P_REQ_NUM(4), .P_UART_DATA_WIDTH(8), .P_HEADER_EN(0)) dut_b (
        .i_clk(i_clk), .w_user_rst(rst), .i_req_valid(b_valid), .i_req_data(b_data),
        .o_req_ready(b_ready), .o_tx_data(b_txd), .o_tx_valid(b_txv), .i_tx_ready(b_txr),
        .o_grant_id(b_gid), .o_busy(b_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    initial begin
        int         nseen;
        logic [3:0] er;
        a_valid = '0; a_data = '0; a_txr = 1'b0;
        b_valid = '0; b_data = '0; b_txr = 1'b0;

        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", 32'(a_ready), 32'h0);
        chk("rst_txv",   32'(a_txv),   32'h0);
        chk("rst_txd",   32'(a_txd),   32'h0);
        chk("rst_gid",   32'(a_gid),   32'h0);
        chk("rst_busy",  32'(a_busy),  32'h0);
        tick(); tick();
        rst = 1'b0;

        // Single request: requester 2 sends 0xA5
        a_txr = 1'b1; a_data = 32'h00A5_0000; a_valid = 4'b0100;
        #1 chk("single_ready", 32'(a_ready), 32'h4);
        tick(); a_valid = '0; #1;
        chk("single_hdr_v",    32'(a_txv),   32'h1);
        chk("single_hdr_d",    32'(a_txd),   32'h02);
        chk("single_hdr_rdy",  32'(a_ready), 32'h0);
        chk("single_hdr_busy", 32'(a_busy),  32'h1);
        chk("single_gid",      32'(a_gid),   32'h2);
        tick(); #1;
        chk("single_dat_v",    32'(a_txv),   32'h1);
        chk("single_dat_d",    32'(a_txd),   32'hA5);
        chk("single_dat_busy", 32'(a_busy),  32'h1);
        tick(); #1;
        chk("single_idle_v",    32'(a_txv),  32'h0);
        chk("single_idle_d",    32'(a_txd),  32'h0);
        chk("single_idle_busy", 32'(a_busy), 32'h0);

        // Pointer wrap: rr_ptr is 3, grant 3, then 0 and 3 both valid
        a_data = 32'h3300_0044; a_valid = 4'b1000;
        #1 chk("wrap_ready3", 32'(a_ready), 32'h8);
        tick(); a_valid = 4'b1001; #1;
        chk("wrap_gid3",     32'(a_gid),   32'h3);
        chk("wrap_hdr_rdy0", 32'(a_ready), 32'h0);
        tick(); tick(); #1;
        chk("wrap_ready0", 32'(a_ready), 32'h1);

        // Backpressure during DATA of requester 0
        tick(); a_valid = 4'b0010; a_data = 32'h0000_6644; #1;
        chk("bp_hdr_gid", 32'(a_gid), 32'h0);
        chk("bp_hdr_d",   32'(a_txd), 32'h00);
        tick(); a_txr = 1'b0; #1;
        chk("bp_dat_d", 32'(a_txd), 32'h44);
        for (int c = 0; c < 20; c++) begin
            tick(); #1;
            chk("bp_hold_v",   32'(a_txv),   32'h1);
            chk("bp_hold_d",   32'(a_txd),   32'h44);
            chk("bp_hold_rdy", 32'(a_ready), 32'h0);
        end
        a_txr = 1'b1;
        tick(); #1;
        chk("bp_release_v",   32'(a_txv),   32'h0);
        chk("bp_release_rdy", 32'(a_ready), 32'h2);

        // Reset mid-frame while requester 1's header is presented
        tick(); a_valid = '0; #1;
        chk("mrst_pre_v",   32'(a_txv), 32'h1);
        chk("mrst_pre_gid", 32'(a_gid), 32'h1);
        a_valid = 4'b0011; rst = 1'b1; #1;
        chk("mrst_ready", 32'(a_ready), 32'h0);
        chk("mrst_txv",   32'(a_txv),   32'h0);
        chk("mrst_txd",   32'(a_txd),   32'h0);
        chk("mrst_gid",   32'(a_gid),   32'h0);
        chk("mrst_busy",  32'(a_busy),  32'h0);
        rst = 1'b0; #1;
        chk("mrst_after_rdy", 32'(a_ready), 32'h1);
        tick(); a_valid = '0; #1;
        chk("mrst_after_gid", 32'(a_gid), 32'h0);
        chk("mrst_after_hdr", 32'(a_txd), 32'h00);
        tick(); #1;
        chk("mrst_after_dat", 32'(a_txd), 32'h44);
        tick();

        // Three requesters, header on: (id, data) pairs in round-robin order from rr_ptr=1
        a_data = 32'h0072_7170; a_valid = 4'b0111; nseen = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (a_txv) begin
                if (nseen < 8) chk("rr3_word", 32'(a_txd), 32'(rr_exp[nseen]));
                nseen++;
            end
            tick();
        end
        chk("rr3_count", 32'(nseen), 32'd8);
        a_valid = '0;

        // Fairness, header off: all four valid continuously
        b_txr = 1'b1; b_data = 32'h1312_1110; b_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            #1;
            er = (c % 2 == 0) ? 4'(1 << ((c / 2) % 4)) : 4'b0000;
            chk("fair_ready", 32'(b_ready), 32'(er));
            chk("fair_txv",   32'(b_txv),   32'(c % 2));
            if (c % 2 == 1) chk("fair_word", 32'(b_txd), 32'(8'h10 + (c / 2) % 4));
            tick();
        end

        // Only requester 2 valid: granted back-to-back
        b_valid = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("solo_ready", 32'(b_ready), (c % 2 == 0) ? 32'h4 : 32'h0);
            if (c % 2 == 1) chk("solo_word", 32'(b_txd), 32'h12);
            tick();
        end
        b_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_drive` transmit path among `P_REQ_NUM` user requesters. It sits between the requesters and `uart_drive`'s `i_user_tx_data`/`i_user_tx_valid`/`o_user_tx_ready` port. It accepts one word per grant. It can prefix each word with a header word carrying the requester index, so the receiving side can demultiplex the stream. All logic runs in the UART user clock domain.

## Interface
Parameters:
- `P_REQ_NUM`, default 4: number of requesters. Legal range is 2..16.
- `P_UART_DATA_WIDTH`, default 8: word width. Must be at least `$clog2(P_REQ_NUM)`.
- `P_HEADER_EN`, default 1: 1 sends a header word (requester index, zero-extended) before each data word. 0 sends data only.

Ports:
- `i_clk`, in, 1: clock.
- `w_user_rst`, in, 1: reset. Asynchronous, active-high.
- `i_req_valid`, in, `P_REQ_NUM`: per-requester word-valid.
- `i_req_data`, in, `P_REQ_NUM*P_UART_DATA_WIDTH`: packed requester words. Requester k occupies bits `[k*W +: W]`.
- `o_req_ready`, out, `P_REQ_NUM`: one-hot accept strobe.
- `o_tx_data`, out, `P_UART_DATA_WIDTH`: word to `uart_drive.i_user_tx_data`.
- `o_tx_valid`, out, 1: to `uart_drive.i_user_tx_valid`.
- `i_tx_ready`, in, 1: from `uart_drive.o_user_tx_ready`.
- `o_grant_id`, out, `$clog2(P_REQ_NUM)`: index of the requester currently being served.
- `o_busy`, out, 1: high in every state except IDLE.

## Operation
- **States:** IDLE, HDR, DATA. A 2-bit state register is used.
- **Requester handshake:**
  - A word transfers when `i_req_valid[k] & o_req_ready[k]` are both high in the same cycle.
  - `o_req_ready` is combinational and asserts only in IDLE, only for the granted index.
  - A requester holds its data stable while its valid bit is high.
- **IDLE:**
  - If any `i_req_valid` bit is set, grant the first set bit searching from `rr_ptr` upward and wrapping modulo `P_REQ_NUM`.
  - On the grant: assert that requester's `o_req_ready` bit, latch its word into `data_q`, latch its index into `o_grant_id`, and set `rr_ptr` to (index+1) mod `P_REQ_NUM`.
  - Next state is HDR if `P_HEADER_EN` is 1, otherwise DATA.
  - With no request, stay in IDLE.
- **HDR:**
  - `o_tx_valid` is 1 and `o_tx_data` is `o_grant_id` zero-extended.
  - When `i_tx_ready` is high, go to DATA.
- **DATA:**
  - `o_tx_valid` is 1 and `o_tx_data` is `data_q`.
  - When `i_tx_ready` is high, go to IDLE.
- **UART handshake:**
  - A transfer occurs when `o_tx_valid & i_tx_ready` are both high.
  - Once raised, `o_tx_valid` and `o_tx_data` stay constant until that transfer.
  - The block never drops valid without a transfer.
- **Boundary conditions:**
  - All requesters valid continuously: grant order is 0,1,2,…,N-1,0.
  - Only one requester valid: it is granted back-to-back.
  - `rr_ptr` wraps from N-1 to 0.
  - `i_tx_ready` stuck low: the block holds in HDR or DATA indefinitely, with `o_req_ready` all 0.
  - A requester dropping valid while not granted is legal and has no effect.
- **Reset (including mid-frame):**
  - State goes to IDLE, `rr_ptr` to 0, `data_q` to 0.
  - The in-flight word is discarded and not replayed.

## Timing
- **Reset values:**
  - `o_req_ready` = 0, `o_tx_valid` = 0, `o_tx_data` = 0, `o_grant_id` = 0, `o_busy` = 0.
  - `o_tx_data` reads 0 whenever state is IDLE.
- **Latency:**
  - Accept cycle T (in IDLE).
  - `o_tx_valid` rises at T+1: header word if `P_HEADER_EN` is 1, data word if 0.
  - With the header enabled, the data word is presented the cycle after the header transfer.
- **Throughput with `i_tx_ready` held high:**
  - 3 cycles per word with the header enabled.
  - 2 cycles per word with the header disabled.
  - One IDLE cycle always separates frames.
- `o_busy` and `o_grant_id` are registered.
- `o_req_ready` and `o_tx_valid` are decoded from the state register (plus the grant logic for `o_req_ready`). No input-to-`o_tx_valid` combinational path exists.

## Test plan
- **Single request:** N=4, header on, `i_tx_ready` held 1, requester 2 sends 0xA5.
  - `o_req_ready` = 4'b0100 for one cycle.
  - Then `o_tx_data` = 0x02 and 0xA5 on consecutive transfers.
  - `o_busy` is high for 2 cycles.
- **Fairness:** all four valid continuously with data 0x10..0x13, header off.
  - UART word sequence is 0x10,0x11,0x12,0x13,0x10.
  - Each `o_req_ready` bit pulses once per 8 cycles.
- **Backpressure:** `i_tx_ready` held 0 for 20 cycles during DATA.
  - `o_tx_valid` stays 1 and `o_tx_data` stays stable.
  - `o_req_ready` stays 0.
  - Exactly one transfer occurs after `i_tx_ready` rises.
- **Pointer wrap:** grant requester 3, then assert only requesters 0 and 3.
  - Requester 0 is served next.
- **Reset mid-frame:** pulse `w_user_rst` while in HDR.
  - All outputs are 0 asynchronously.
  - After reset, requester 0 wins over requester 1 when both are valid.
- **Loopback:** instantiate with `uart_drive` (`P_UART_DATA_WIDTH`=8, TX output looped back to the RX input), 3 requesters, header on.
  - The RX stream decodes as (id, data) pairs matching the injected words, in round-robin order.
